// File: rtl/rf_write_arbiter_if.sv
// Write-back bundle between the requesters, the arbiter and the register file port.
// Carries both requester handshakes, the drain outputs and the queue status.
// CW must match the COUNT width of the arbiter it connects to.
interface rf_write_arbiter_if #(
    parameter int CW = 3
);
    logic          HOLD;
    logic          A_VALID;
    logic [2:0]    A_ADDR;
    logic [7:0]    A_DATA;
    logic          A_READY;
    logic          M_VALID;
    logic [2:0]    M_ADDR;
    logic [7:0]    M_DATA;
    logic          M_READY;
    logic          RF_WRITE;
    logic [2:0]    RF_INADDRESS;
    logic [7:0]    RF_IN;
    logic [7:0]    PENDING;
    logic [CW-1:0] COUNT;
    logic          FULL;
    logic          EMPTY;

    // Pipeline side: raises requests and the stall, observes grants and queue state.
    modport master (
        output HOLD, A_VALID, A_ADDR, A_DATA, M_VALID, M_ADDR, M_DATA,
        input  A_READY, M_READY, RF_WRITE, RF_INADDRESS, RF_IN, PENDING, COUNT, FULL, EMPTY
    );

    // Arbiter side.
    modport slave (
        input  HOLD, A_VALID, A_ADDR, A_DATA, M_VALID, M_ADDR, M_DATA,
        output A_READY, M_READY, RF_WRITE, RF_INADDRESS, RF_IN, PENDING, COUNT, FULL, EMPTY
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU (A) and load (M) write-backs into an in-order FIFO draining to the RF write port.
// Latency: accepted at edge N into an empty queue, written to the RF at edge N+1; grants are combinational.
// Backpressure: READY only while free slots exist (no pop pass-through); HOLD freezes the drain only.
// Optional macro WBARB_FIXED_PRIO_EN: load requester always wins contention and is queued first.
module rf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RESET,
    rf_write_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]    addr_q [DEPTH];
    logic [7:0]    data_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          win_m;
    logic          a_rdy;
    logic          m_rdy;
    logic          push_a;
    logic          push_m;
    logic [1:0]    n_push;
    logic          pop;
    logic [2:0]    first_addr;
    logic [7:0]    first_data;
    logic [2:0]    second_addr;
    logic [7:0]    second_data;
    logic          empty;
    logic [7:0]    pending;
    logic [AW-1:0] slot_off;

    assign free  = CW'(DEPTH) - count;
    assign empty = (count == '0);

`ifdef WBARB_FIXED_PRIO_EN
    assign win_m = 1'b1;
`else
    logic rr;

    // Round-robin flag flips after every cycle in which both requesters competed for space.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr <= 1'b0;
        end else if (bus.A_VALID && bus.M_VALID && (free != '0)) begin
            rr <= ~rr;
        end
    end

    assign win_m = rr;
`endif

    // Grants from registered occupancy only; a single free slot goes to the winner under contention.
    always_comb begin
        a_rdy = 1'b0;
        m_rdy = 1'b0;
        if (!RESET) begin
            if (free >= CW'(2)) begin
                a_rdy = bus.A_VALID;
                m_rdy = bus.M_VALID;
            end else if (free == CW'(1)) begin
                if (bus.A_VALID && bus.M_VALID) begin
                    a_rdy = ~win_m;
                    m_rdy = win_m;
                end else begin
                    a_rdy = bus.A_VALID;
                    m_rdy = bus.M_VALID;
                end
            end
        end
    end

    assign push_a = bus.A_VALID & a_rdy;
    assign push_m = bus.M_VALID & m_rdy;
    assign n_push = {1'b0, push_a} + {1'b0, push_m};
    assign pop    = ~empty & ~bus.HOLD & ~RESET;

    // Order the accepted writes: the winner lands first so the loser's data ends up in the register.
    always_comb begin
        first_addr  = bus.A_ADDR;
        first_data  = bus.A_DATA;
        second_addr = bus.M_ADDR;
        second_data = bus.M_DATA;
        if (push_a && push_m) begin
            if (win_m) begin
                first_addr  = bus.M_ADDR;
                first_data  = bus.M_DATA;
                second_addr = bus.A_ADDR;
                second_data = bus.A_DATA;
            end
        end else if (push_m) begin
            first_addr = bus.M_ADDR;
            first_data = bus.M_DATA;
        end
    end

    // Entry storage; contents of unoccupied slots are never observed, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (n_push != 2'd0) begin
                addr_q[wr_ptr] <= first_addr;
                data_q[wr_ptr] <= first_data;
            end
            if (n_push == 2'd2) begin
                addr_q[wr_ptr + AW'(1)] <= second_addr;
                data_q[wr_ptr + AW'(1)] <= second_data;
            end
        end
    end

    // Pointers and occupancy; reset discards everything queued and beats any push or pop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

    // Pending mask: every occupied slot, head included, flags its destination register.
    always_comb begin
        pending  = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = AW'(i) - rd_ptr;
            if ({1'b0, slot_off} < count) begin
                pending[addr_q[i]] = 1'b1;
            end
        end
    end

    assign bus.A_READY      = a_rdy;
    assign bus.M_READY      = m_rdy;
    assign bus.RF_WRITE     = pop;
    assign bus.RF_INADDRESS = empty ? 3'd0 : addr_q[rd_ptr];
    assign bus.RF_IN        = empty ? 8'd0 : data_q[rd_ptr];
    assign bus.PENDING      = pending;
    assign bus.COUNT        = count;
    assign bus.FULL         = (count == CW'(DEPTH));
    assign bus.EMPTY        = empty;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Inputs change on the falling edge and outputs are compared 1 time unit later.
// A shadow register file records what the DUT actually writes.
module tb_rf_write_arbiter;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WBARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } ent_t;

    logic CLK;
    logic RESET;
    rf_write_arbiter_if #(.CW(CW)) bus();

    rf_write_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;

    // shadow register file fed by the DUT's write port
    logic [7:0] rf_dut [8];
    int         wr_cnt = 0;
    always @(posedge CLK) begin
        if (bus.RF_WRITE === 1'b1) begin
            rf_dut[bus.RF_INADDRESS] <= bus.RF_IN;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // behavioural model state
    ent_t q[$];
    bit   m_rr;
    bit   e_ar, e_mr, e_wr;
    logic [2:0] e_addr;
    logic [7:0] e_data, e_pend;
    int   e_free;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // derive expected outputs from the queue contents and current inputs, then compare
    task automatic cmp_cycle();
        bit wm;
        #1;
        e_free = DEPTH - q.size();
        wm = FIXED ? 1'b1 : m_rr;
        e_ar = 0;
        e_mr = 0;
        if (!RESET) begin
            if (e_free >= 2) begin
                e_ar = bus.A_VALID;
                e_mr = bus.M_VALID;
            end else if (e_free == 1) begin
                if (bus.A_VALID && bus.M_VALID) begin
                    e_ar = !wm;
                    e_mr = wm;
                end else begin
                    e_ar = bus.A_VALID;
                    e_mr = bus.M_VALID;
                end
            end
        end
        e_wr   = (q.size() > 0) && !bus.HOLD && !RESET;
        e_addr = (q.size() > 0) ? q[0].a : 3'd0;
        e_data = (q.size() > 0) ? q[0].d : 8'd0;
        e_pend = 8'd0;
        foreach (q[k]) e_pend[q[k].a] = 1'b1;
        chk("A_READY",      32'(bus.A_READY),      32'(e_ar));
        chk("M_READY",      32'(bus.M_READY),      32'(e_mr));
        chk("RF_WRITE",     32'(bus.RF_WRITE),     32'(e_wr));
        chk("RF_INADDRESS", 32'(bus.RF_INADDRESS), 32'(e_addr));
        chk("RF_IN",        32'(bus.RF_IN),        32'(e_data));
        chk("PENDING",      32'(bus.PENDING),      32'(e_pend));
        chk("COUNT",        32'(bus.COUNT),        32'(q.size()));
        chk("FULL",         32'(bus.FULL),         32'(q.size() == DEPTH));
        chk("EMPTY",        32'(bus.EMPTY),        32'(q.size() == 0));
    endtask

    // apply the coming clock edge to the model, then move to the next falling edge
    task automatic adv();
        ent_t ea, em;
        bit wm;
        wm = FIXED ? 1'b1 : m_rr;
        ea = '{a: bus.A_ADDR, d: bus.A_DATA};
        em = '{a: bus.M_ADDR, d: bus.M_DATA};
        if (RESET) begin
            q.delete();
            m_rr = 0;
        end else begin
            if (e_wr) void'(q.pop_front());
            if (e_ar && e_mr) begin
                if (wm) begin q.push_back(em); q.push_back(ea); end
                else    begin q.push_back(ea); q.push_back(em); end
            end else if (e_ar) q.push_back(ea);
            else if (e_mr) q.push_back(em);
            if (!FIXED && bus.A_VALID && bus.M_VALID && e_free >= 1) m_rr = !m_rr;
        end
        @(negedge CLK);
    endtask

    task automatic cyc();
        cmp_cycle();
        adv();
    endtask

    task automatic drive(input bit hold, input bit av, input logic [2:0] aa, input logic [7:0] ad,
                         input bit mv, input logic [2:0] ma, input logic [7:0] md);
        bus.HOLD    = hold;
        bus.A_VALID = av;
        bus.A_ADDR  = aa;
        bus.A_DATA  = ad;
        bus.M_VALID = mv;
        bus.M_ADDR  = ma;
        bus.M_DATA  = md;
    endtask

    task automatic idle(input bit hold);
        drive(hold, 0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    endtask

    initial begin
        int snap;
        RESET = 1'b1;
        idle(0);
        m_rr = 0;
        @(negedge CLK);
        cyc();
        RESET = 1'b0;

        // reset state
        cmp_cycle();
        chk("rst_COUNT", 32'(bus.COUNT), 32'd0);
        chk("rst_EMPTY", 32'(bus.EMPTY), 32'd1);
        chk("rst_FULL", 32'(bus.FULL), 32'd0);
        chk("rst_RF_WRITE", 32'(bus.RF_WRITE), 32'd0);
        adv();

        // single push, write one edge later
        drive(0, 1, 3'd3, 8'h2A, 0, 3'd0, 8'd0);
        cmp_cycle();
        chk("t1_A_READY", 32'(bus.A_READY), 32'd1);
        adv();
        idle(0);
        cmp_cycle();
        chk("t1_RF_WRITE", 32'(bus.RF_WRITE), 32'd1);
        chk("t1_ADDR", 32'(bus.RF_INADDRESS), 32'd3);
        chk("t1_DATA", 32'(bus.RF_IN), 32'h2A);
        chk("t1_PENDING", 32'(bus.PENDING), 32'h08);
        adv();
        cmp_cycle();
        chk("t1_RF_WRITE_off", 32'(bus.RF_WRITE), 32'd0);
        chk("t1_PENDING_off", 32'(bus.PENDING), 32'h00);
        adv();

        // dual push to the same register
        drive(0, 1, 3'd5, 8'h11, 1, 3'd5, 8'h22);
        cyc();
        idle(0);
        cmp_cycle();
        chk("t2_first", 32'(bus.RF_IN), FIXED ? 32'h22 : 32'h11);
        adv();
        cmp_cycle();
        chk("t2_second", 32'(bus.RF_IN), FIXED ? 32'h11 : 32'h22);
        adv();
        chk("t2_R5", 32'(rf_dut[5]), FIXED ? 32'h11 : 32'h22);

        // fill under HOLD
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 3'(i), 8'(8'h40 + i), 0, 3'd0, 8'd0);
            cyc();
        end
        drive(1, 1, 3'd6, 8'h66, 1, 3'd7, 8'h77);
        cmp_cycle();
        chk("t3_FULL", 32'(bus.FULL), 32'd1);
        chk("t3_COUNT", 32'(bus.COUNT), 32'd4);
        chk("t3_A_READY", 32'(bus.A_READY), 32'd0);
        chk("t3_M_READY", 32'(bus.M_READY), 32'd0);
        chk("t3_RF_WRITE", 32'(bus.RF_WRITE), 32'd0);
        chk("t3_PENDING", 32'(bus.PENDING), 32'h1E);
        adv();
        idle(0);
        for (int i = 1; i <= 4; i++) begin
            cmp_cycle();
            chk("t3_drain_addr", 32'(bus.RF_INADDRESS), 32'(i));
            chk("t3_drain_wr", 32'(bus.RF_WRITE), 32'd1);
            adv();
        end
        cmp_cycle();
        chk("t3_EMPTY", 32'(bus.EMPTY), 32'd1);
        adv();

        // contention with one free slot; first bring RR back to A via a contended dual push
        drive(1, 1, 3'd0, 8'h01, 1, 3'd1, 8'h02);
        cyc();
        drive(1, 1, 3'd2, 8'h03, 0, 3'd0, 8'd0);
        cyc();
        drive(1, 1, 3'd3, 8'h04, 1, 3'd4, 8'h05);
        cmp_cycle();
        chk("t4_g1_A", 32'(bus.A_READY), FIXED ? 32'd0 : 32'd1);
        chk("t4_g1_M", 32'(bus.M_READY), FIXED ? 32'd1 : 32'd0);
        adv();
        idle(0);
        cyc();
        drive(1, 1, 3'd3, 8'h04, 1, 3'd4, 8'h05);
        cmp_cycle();
        chk("t4_g2_A", 32'(bus.A_READY), 32'd0);
        chk("t4_g2_M", 32'(bus.M_READY), 32'd1);
        adv();
        idle(0);
        for (int i = 0; i < 5; i++) cyc();

        // reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 3'(i), 8'(8'h90 + i), 0, 3'd0, 8'd0);
            cyc();
        end
        idle(0);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        snap = wr_cnt;
        cmp_cycle();
        chk("t5_COUNT", 32'(bus.COUNT), 32'd0);
        chk("t5_EMPTY", 32'(bus.EMPTY), 32'd1);
        chk("t5_PENDING", 32'(bus.PENDING), 32'd0);
        chk("t5_RF_WRITE", 32'(bus.RF_WRITE), 32'd0);
        adv();
        cyc();
        cyc();
        chk("t5_no_writes", 32'(wr_cnt), 32'(snap));

        // wrap-around
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 3'(i % 8), 8'(8'h80 + i), 0, 3'd0, 8'd0);
            cyc();
            idle(0);
            cmp_cycle();
            chk("t6_addr", 32'(bus.RF_INADDRESS), 32'(i % 8));
            chk("t6_data", 32'(bus.RF_IN), 32'(8'h80 + i));
            chk("t6_wr", 32'(bus.RF_WRITE), 32'd1);
            adv();
        end

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            RESET = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 3,
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            cyc();
        end
        RESET = 1'b0;
        idle(0);
        for (int i = 0; i < 6; i++) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two write-back requesters: A (ALU result) and M (data-memory load result).
- Accepted writes go into a shared in-order FIFO, which drains one write per cycle into the register file's IN/INADDRESS/WRITE inputs.
- Drain stalls while HOLD is high.
- A per-register pending-write mask lets decode detect read-after-write hazards on queued writes.

Parameters:
- DEPTH, 4, number of FIFO entries. Power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of COUNT.

Ports:
- CLK  input  1  clock, all state changes on posedge
- RESET  input  1  synchronous reset, active-high
- HOLD  input  1  stall; no drain while high
- A_VALID  input  1  ALU write request
- A_ADDR  input  3  ALU destination register
- A_DATA  input  8  ALU write data (signed)
- A_READY  output  1  ALU request accepted this cycle
- M_VALID  input  1  load write request
- M_ADDR  input  3  load destination register
- M_DATA  input  8  load write data (signed)
- M_READY  output  1  load request accepted this cycle
- RF_WRITE  output  1  drives register file WRITE
- RF_INADDRESS  output  3  drives register file INADDRESS
- RF_IN  output  8  drives register file IN
- PENDING  output  8  bit i high = a queued write targets Ri
- COUNT  output  CW  occupied entries
- FULL  output  1  COUNT==DEPTH
- EMPTY  output  1  COUNT==0

Behaviour:
- Reset: RESET is synchronous, active-high, on CLK. On reset:
  - COUNT, read/write pointers and PENDING go to 0.
  - Round-robin pointer RR goes to 0 (A first).
  - FULL=0, EMPTY=1, RF_WRITE=0, A_READY=M_READY=0.
  - Queued entries are discarded, including on reset mid-operation.
  - RESET has priority over push and pop in the same cycle.
- Free slots: FREE = DEPTH - COUNT, from registered state only. A pop in the same cycle does not create space (no pass-through).
- Winner: W = A if RR==0, else M.
- Ready rules (combinational from VALIDs and registered state; both 0 while RESET):
  - FREE>=2: A_READY=A_VALID, M_READY=M_VALID.
  - FREE==1, only one VALID: that requester gets READY.
  - FREE==1, both VALID: only W gets READY.
  - FREE==0: both READY=0.
- Push: a request is accepted at the posedge where VALID&READY. When both are accepted, W is written first and the other second, so on equal addresses the loser's data is the final register value.
- RR update: RR toggles after every contended cycle (both VALID and FREE>=1). Otherwise it holds.
- Drain:
  - RF_WRITE = !EMPTY & !HOLD & !RESET.
  - RF_INADDRESS and RF_IN always show the head entry, and are 0 when EMPTY.
  - At a posedge with RF_WRITE=1 the head is popped; the register file samples the same edge.
- Latency: a request accepted at edge N into an empty FIFO appears at the head after N and is written at edge N+1 if HOLD is low.
- Simultaneous events: push and pop in one cycle give COUNT += pushes - 1. COUNT never exceeds DEPTH and never underflows.
- Pointers: read and write pointers wrap modulo DEPTH.
- PENDING: OR over occupied entries of onehot(addr), including the head. It clears only when the last entry for that register is popped. It is combinational from registered state.
- HOLD: freezes the drain only. Pushes continue while space remains.

Optional Feature:
- Macro: WBARB_FIXED_PRIO_EN.
- When defined: RR is removed and W is always M. Load returns win every contended cycle and are pushed before A in dual accepts.
- When undefined: round-robin as above.

Test Plan:
1. Single push, HOLD=0: A_VALID with A_ADDR=3, A_DATA=0x2A for one cycle. RF_WRITE is high for exactly one cycle, one edge later, with RF_INADDRESS=3 and RF_IN=0x2A. PENDING=0x08 during that window, then 0.
2. Dual push, same address, RR=0: A(5, 0x11) and M(5, 0x22) in the same cycle. Two consecutive writes to R5, 0x11 then 0x22. R5 ends at 0x22 and RR=1 afterwards. With WBARB_FIXED_PRIO_EN the order is 0x22 then 0x11.
3. HOLD fill: HOLD=1, push 4 entries (R1..R4), then A_VALID and M_VALID both high. FULL=1, COUNT=4, both READY=0, RF_WRITE=0, PENDING=0x1E. Release HOLD: four writes R1,R2,R3,R4 in order on four consecutive edges, then EMPTY=1.
4. Contention at FREE==1: COUNT=3, HOLD=1, both VALID on two consecutive cycles with a pop allowed between them. The first grant goes to A (RR=0) and the second to M. Verify A_READY/M_READY alternate.
5. Reset mid-operation: COUNT=3 with HOLD=0, assert RESET for one cycle. Next cycle COUNT=0, EMPTY=1, PENDING=0, RF_WRITE=0, and no further writes reach the register file.
6. Wrap-around: 10 sequential single pushes interleaved with pops (addresses 0..7,0,1 with data = 0x80+i). Register writes occur in issue order with matching data across pointer wrap.
